vga_scanout_controller: RTL and testbench

Pixel consumer directly downstream of the data fetching engine. It generates VGA horizontal and vertical timing and accepts one 12-bit RGB444 pixel per clock during active video over an rts/rtr handshake. It drives the registered colour and sync pins, and produces the `en_fetching` gate that resets and restarts the fetch pipeline once per frame. `clk` is the pixel clock: one clock is one pixel.

---
 rtl/vga_scanout_controller.sv | 150 +++++++++++++++
 tb/tb_vga_scanout_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout_controller.sv
// vga_scanout_controller
//
// Pixel-clock VGA timing generator and pixel sink. Counts horizontal and
// vertical position, accepts one RGB444 pixel per active slot over an
// rts/rtr handshake, and drives registered colour/sync pins. Also produces
// en_fetching, which holds the upstream fetch pipeline in reset during the
// vsync lines so it restarts from the top of the frame once per frame.
//
// Ports:
//   clk            pixel clock, rising edge
//   rst_           asynchronous active-low reset
//   in_data[11:0]  pixel {R[11:8], G[7:4], B[3:0]}
//   in_rts         upstream has a valid pixel
//   in_rtr         ready to receive (= active video, from counters only)
//   en_fetching    fetch enable, low during the vsync lines
//   hsync, vsync   sync pins, asserted level SYNC_POL
//   vga_r/g/b      colour pins, 0 during blanking and missed slots
//   frame_start    one-cycle pulse while the pins show pixel (0,0)
//   underflow      sticky flag, set when an active slot had no pixel
//   clr_underflow  synchronous clear of underflow (a same-cycle set wins)
module vga_scanout_controller #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic [11:0] in_data,
    input  logic        in_rts,
    output logic        in_rtr,
    output logic        en_fetching,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start,
    output logic        underflow,
    input  logic        clr_underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 10-bit counters cannot represent a line or frame longer than 1024.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
            $error("vga_scanout_controller: H_TOTAL/V_TOTAL must be <= 1024");
        end
    endgenerate

    // Window bounds are 11 bits so an exclusive end equal to 1024 still works.
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_START  = 10'(V_ACTIVE);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEGIN = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [10:0] h_ext;
    logic [10:0] v_ext;
    logic        h_wrap;
    logic        v_wrap;
    logic        active;
    logic        xfer;
    logic        miss;
    logic        hs_win;
    logic        vs_win;

    logic        hsync_p1;
    logic        vsync_p1;
    logic        en_fetching_p1;
    logic [11:0] rgb_p1;
    logic        frame_start_p1;
    logic        underflow_p1;

    always_comb begin
        h_ext  = {1'b0, h_cnt};
        v_ext  = {1'b0, v_cnt};
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        active = (h_ext < H_ACT) && (v_ext < V_ACT);
        xfer   = active && in_rts;
        miss   = active && !in_rts;
        hs_win = (h_ext >= HS_BEGIN) && (h_ext < HS_END);
        vs_win = (v_ext >= VS_BEGIN) && (v_ext < VS_END);
    end

    assign in_rtr = active;

    // Stage p0: raster position. Reset lands on the first front-porch line so
    // a complete vertical blanking interval precedes the first visible line.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            h_cnt <= 10'd0;
            v_cnt <= V_START;
        end else begin
            h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
            end
        end
    end

    // Stage p1: every pin is registered from the same counter state, so sync
    // and colour stay aligned with a uniform one-clock latency.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            hsync_p1       <= ~SYNC_POL;
            vsync_p1       <= ~SYNC_POL;
            en_fetching_p1 <= 1'b0;
            rgb_p1         <= 12'd0;
            frame_start_p1 <= 1'b0;
            underflow_p1   <= 1'b0;
        end else begin
            hsync_p1       <= hs_win ? SYNC_POL : ~SYNC_POL;
            vsync_p1       <= vs_win ? SYNC_POL : ~SYNC_POL;
            en_fetching_p1 <= !vs_win;
            rgb_p1         <= xfer ? in_data : 12'd0;
            frame_start_p1 <= active && (h_cnt == 10'd0) && (v_cnt == 10'd0);
            // A new miss outranks a clear in the same cycle.
            if (miss) begin
                underflow_p1 <= 1'b1;
            end else if (clr_underflow) begin
                underflow_p1 <= 1'b0;
            end
        end
    end

    assign hsync       = hsync_p1;
    assign vsync       = vsync_p1;
    assign en_fetching = en_fetching_p1;
    assign vga_r       = rgb_p1[11:8];
    assign vga_g       = rgb_p1[7:4];
    assign vga_b       = rgb_p1[3:0];
    assign frame_start = frame_start_p1;
    assign underflow   = underflow_p1;

endmodule

// File: tb/tb_vga_scanout_controller.sv
// Bench for vga_scanout_controller using a reduced raster (24 x 15, 360
// clocks per frame). A position model derived from elapsed clocks since reset
// release predicts every pin each cycle; literal expectations pin the model.
module tb_vga_scanout_controller;

    localparam int   HA  = 16;
    localparam int   HF  = 2;
    localparam int   HS  = 3;
    localparam int   HB  = 3;
    localparam int   VA  = 8;
    localparam int   VF  = 2;
    localparam int   VS  = 2;
    localparam int   VB  = 3;
    localparam int   HT  = HA + HF + HS + HB;
    localparam int   VT  = VA + VF + VS + VB;
    localparam int   FR  = HT * VT;
    localparam logic POL = 1'b0;

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic [11:0] in_data = 12'd0;
    logic        in_rts = 1'b0;
    logic        clr_underflow = 1'b0;
    logic        in_rtr;
    logic        en_fetching;
    logic        hsync;
    logic        vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        frame_start;
    logic        underflow;

    vga_scanout_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL)
    ) dut (
        .clk(clk), .rst_(rst_), .in_data(in_data), .in_rts(in_rts),
        .in_rtr(in_rtr), .en_fetching(en_fetching), .hsync(hsync),
        .vsync(vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start), .underflow(underflow),
        .clr_underflow(clr_underflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Raster position after kk clocks since reset release.
    function automatic int ph(input int kk);
        return ((VA * HT + kk) % FR) % HT;
    endfunction
    function automatic int pv(input int kk);
        return ((VA * HT + kk) % FR) / HT;
    endfunction
    function automatic logic act_f(input int kk);
        return (ph(kk) < HA) && (pv(kk) < VA);
    endfunction

    // Reference model: expected pins after each edge.
    int          k;
    logic        e_hs, e_vs, e_en, e_fs, e_uf;
    logic [11:0] e_rgb;

    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            k     <= 0;
            e_hs  <= ~POL;
            e_vs  <= ~POL;
            e_en  <= 1'b0;
            e_rgb <= 12'd0;
            e_fs  <= 1'b0;
            e_uf  <= 1'b0;
        end else begin
            e_hs  <= (ph(k) >= HA + HF && ph(k) < HA + HF + HS) ? POL : ~POL;
            e_vs  <= (pv(k) >= VA + VF && pv(k) < VA + VF + VS) ? POL : ~POL;
            e_en  <= !(pv(k) >= VA + VF && pv(k) < VA + VF + VS);
            e_rgb <= (act_f(k) && in_rts) ? in_data : 12'd0;
            e_fs  <= act_f(k) && ph(k) == 0 && pv(k) == 0;
            e_uf  <= (act_f(k) && !in_rts) ? 1'b1 : (clr_underflow ? 1'b0 : e_uf);
            k     <= k + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("hsync", int'(hsync), int'(e_hs));
            chk("vsync", int'(vsync), int'(e_vs));
            chk("en_fetching", int'(en_fetching), int'(e_en));
            chk("rgb", int'({vga_r, vga_g, vga_b}), int'(e_rgb));
            chk("frame_start", int'(frame_start), int'(e_fs));
            chk("underflow", int'(underflow), int'(e_uf));
            chk("in_rtr", int'(in_rtr), int'(act_f(k)));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic rts, input logic clr);
        in_rts        = rts;
        clr_underflow = clr;
        in_data       = act_f(k) ? 12'((pv(k) * HA + ph(k)) % 4096) : 12'($urandom);
    endtask

    task automatic chk_reset_pins(input string tag);
        chk({tag, "_hsync"}, int'(hsync), 1);
        chk({tag, "_vsync"}, int'(vsync), 1);
        chk({tag, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
        chk({tag, "_underflow"}, int'(underflow), 0);
        chk({tag, "_en_fetching"}, int'(en_fetching), 0);
        chk({tag, "_in_rtr"}, int'(in_rtr), 0);
    endtask

    initial begin
        int rtr_hi, vs_lo, en_lo, hs_lo, fs_cnt, i_fs, last_fall, n;
        logic hs_prev, fall_done, found;
        int h, v;

        rtr_hi = 0; vs_lo = 0; en_lo = 0; hs_lo = 0; fs_cnt = 0;
        i_fs = -1; last_fall = -1; hs_prev = 1'b1; fall_done = 1'b0;

        #1 rst_ = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_pins("reset");
        chk_en = 1'b1;
        rst_ = 1'b1;

        // Two frames of uninterrupted pixels.
        for (int i = 0; i < 2 * FR; i++) begin
            drive(1'b1, 1'b0);
            if (in_rtr) rtr_hi++;
            step();
            if (!vsync) vs_lo++;
            if (!en_fetching) en_lo++;
            if (!hsync) hs_lo++;
            if (frame_start) begin
                fs_cnt++;
                if (i_fs < 0) i_fs = i;
                chk("pixel00_value", int'({vga_r, vga_g, vga_b}), 0);
            end
            if (hs_prev && !hsync) begin
                if (last_fall >= 0) chk("hsync_period", i - last_fall, 24);
                if (i_fs >= 0 && !fall_done) begin
                    chk("hsync_fall_offset", i - i_fs, 18);
                    fall_done = 1'b1;
                end
                last_fall = i;
            end
            hs_prev = hsync;
        end
        chk("rtr_high_2frames", rtr_hi, 256);
        chk("vsync_low_2frames", vs_lo, 96);
        chk("en_low_2frames", en_lo, 96);
        chk("hsync_low_2frames", hs_lo, 90);
        chk("frame_start_count", fs_cnt, 2);
        chk("first_frame_start_step", i_fs, 168);

        // Targeted misses and clear-versus-set priority.
        for (int i = 0; i < FR; i++) begin
            h = ph(k);
            v = pv(k);
            drive(!((v == 2 && h >= 5 && h <= 7) || (v == 3 && h == 4)),
                  (v == 3 && (h == 4 || h == 6)));
            step();
            if (v == 2 && h == 5) begin
                chk("miss_underflow_set", int'(underflow), 1);
                chk("miss_black", int'({vga_r, vga_g, vga_b}), 0);
            end
            if (v == 2 && h == 8) chk("resume_pixel", int'({vga_r, vga_g, vga_b}), 40);
            if (v == 3 && h == 4) chk("clr_vs_miss", int'(underflow), 1);
            if (v == 3 && h == 6) chk("clr_clean", int'(underflow), 0);
        end

        // Random handshake and clears over three frames.
        for (int i = 0; i < 3 * FR; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            step();
        end

        // Run to line 5, x = 10 with a miss just before it, then reset
        // asynchronously between edges.
        found = 1'b0;
        for (int i = 0; i < 2 * FR && !found; i++) begin
            if (pv(k) == 5 && ph(k) == 10) begin
                found = 1'b1;
            end else begin
                drive(ph(k) != 9, 1'b0);
                step();
            end
        end
        chk("reached_reset_point", int'(found), 1);
        chk("underflow_before_reset", int'(underflow), 1);
        #2 rst_ = 1'b0;
        #1;
        chk_reset_pins("async_reset");
        repeat (3) @(negedge clk);
        #1 rst_ = 1'b1;

        n = 0;
        while (!in_rtr && n < 1000) begin
            drive(1'b1, 1'b0);
            step();
            n++;
        end
        chk("first_rtr_after_release", n, 168);
        chk("no_frame_start_yet", int'(frame_start), 0);
        drive(1'b1, 1'b0);
        step();
        chk("frame_start_after_release", int'(frame_start), 1);
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b0);
            step();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
